// File: rtl/vt_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vt_decode                                                  |
// | Description : Sequential single-deletion-correcting Varshamov-Tenengolts |
// |               decoder. Accepts a full N-bit word or an (N-1)-bit word    |
// |               with one deleted bit. It accumulates the VT checksum one   |
// |               bit per cycle, reinserts a deleted bit when the residue    |
// |               allows it, and extracts the K information bits.            |
// |               Modulus is 2N+1, residue SYNDROME_VAL.                     |
// | Ports       : clk, rst_n          clock, async active-low reset          |
// |               in_valid/in_ready   input handshake                        |
// |               in_word[N-1:0]      received word, bit i = position i+1    |
// |               in_full             1 = N-bit word, 0 = one deletion       |
// |               out_valid/out_ready output handshake                       |
// |               data_out[K-1:0]     decoded information bits               |
// |               corrected           a deleted bit was reinserted           |
// |               err                 word not decodable                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vt_decode #(
    parameter int K            = 5,
    parameter int N            = 10,
    parameter int SYNDROME_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_word,
    input  logic         in_full,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] data_out,
    output logic         corrected,
    output logic         err
);

    // N is expected to be the smallest length with N - clog2(N) - 1 >= K,
    // matching the encoder; the data map below assumes that pairing.
    localparam int c_m     = 2 * N + 1;
    localparam int c_sum_w = $clog2(N * (N + 1) / 2 + 1);
    localparam int c_wt_w  = $clog2(N + 1);
    localparam int c_d_w   = $clog2(c_m);
    localparam int c_cnt_w = $clog2(N);
    localparam int c_cw    = c_sum_w + c_d_w;

    localparam logic [c_cw-1:0]    c_mod  = c_cw'(c_m);
    localparam logic [c_cw-1:0]    c_res  = c_cw'(SYNDROME_VAL % c_m);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

    // Index of the j-th data bit in the codeword. Parity sits at every
    // index i with (i+1)&i == 0, and also at N-1 when the power-of-two
    // parities plus the tail bit still leave room.
    function automatic int data_idx(input int j);
        int   lp;
        int   cnt;
        int   res;
        logic tail;
        lp = 0;
        for (int i = 0; i < N; i++) begin
            if (((i + 1) & i) == 0) lp = i;
        end
        tail = (K + $clog2(lp + 1) + 1) < N;
        cnt  = 0;
        res  = 0;
        for (int i = 0; i < N; i++) begin
            if (!((((i + 1) & i) == 0) || (tail && (i == N - 1)))) begin
                if (cnt == j) res = i;
                cnt++;
            end
        end
        return res;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SUM     = 3'd1,
        S_CHECK   = 3'd2,
        S_LOCATE  = 3'd3,
        S_EXTRACT = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [N-1:0]        r_word;
    logic                r_full;
    logic [c_sum_w-1:0]  r_sum;
    logic [c_wt_w-1:0]   r_weight;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_d_w-1:0]    r_d;
    logic [c_wt_w-1:0]   r_ones;   // ones in y[0..p-1] while locating
    logic                r_found;
    logic [c_cnt_w-1:0]  r_pos;
    logic                r_ins;
    logic                r_err;

    logic                w_bit;
    logic [c_d_w-1:0]    w_d;
    logic                w_d_big;
    logic                w_match;
    logic [N-1:0]        w_fixed;
    logic [N-1:0]        w_final;
    logic [K-1:0]        w_data;

    assign w_bit = r_word[r_cnt];

    // D = (a - sum) mod m, always in 0..m-1.
    assign w_d     = c_d_w'((c_res + c_mod - (c_cw'(r_sum) % c_mod)) % c_mod);
    assign w_d_big = c_cw'(w_d) > c_cw'(N);

    // Candidate insertion point p = r_cnt. A deleted 0 leaves D ones to its
    // right; a deleted 1 leaves D-weight-1 zeros to its left.
    always_comb begin
        w_match = 1'b0;
        if (c_cw'(r_d) <= c_cw'(r_weight)) begin
            w_match = (c_cw'(r_weight) - c_cw'(r_ones)) == c_cw'(r_d);
        end else begin
            w_match = (c_cw'(r_cnt) - c_cw'(r_ones)) ==
                      (c_cw'(r_d) - c_cw'(r_weight) - c_cw'(1));
        end
    end

    // Rebuilt word: below p unchanged, p holds the inserted bit, above p
    // shifted up by one.
    for (genvar j = 0; j < N; j++) begin : g_rebuild
        if (j == 0) begin : g_first
            assign w_fixed[j] = (r_pos == '0) ? r_ins : r_word[0];
        end else begin : g_rest
            assign w_fixed[j] = (c_cnt_w'(j) < r_pos)  ? r_word[j] :
                                (c_cnt_w'(j) == r_pos) ? r_ins     :
                                                         r_word[j-1];
        end
    end

    assign w_final = r_found ? w_fixed : r_word;

    for (genvar j = 0; j < K; j++) begin : g_data
        localparam int c_idx = data_idx(j);
        assign w_data[j] = w_final[c_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SUM;
            end
            S_SUM: begin
                if (r_cnt == c_last) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (r_full || w_d_big) w_next = S_EXTRACT;
                else                   w_next = S_LOCATE;
            end
            S_LOCATE: begin
                if (r_cnt == c_last) w_next = S_EXTRACT;
            end
            S_EXTRACT: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word    <= '0;
            r_full    <= 1'b0;
            r_sum     <= '0;
            r_weight  <= '0;
            r_cnt     <= '0;
            r_d       <= '0;
            r_ones    <= '0;
            r_found   <= 1'b0;
            r_pos     <= '0;
            r_ins     <= 1'b0;
            r_err     <= 1'b0;
            data_out  <= '0;
            corrected <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // The top bit of a short word is channel garbage.
                        r_word   <= in_full ? in_word : {1'b0, in_word[N-2:0]};
                        r_full   <= in_full;
                        r_sum    <= '0;
                        r_weight <= '0;
                        r_cnt    <= '0;
                        r_ones   <= '0;
                        r_found  <= 1'b0;
                        r_pos    <= '0;
                        r_ins    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                S_SUM: begin
                    r_sum    <= r_sum + (w_bit ? (c_sum_w'(r_cnt) + c_sum_w'(1))
                                               : c_sum_w'(0));
                    r_weight <= r_weight + c_wt_w'(w_bit);
                    r_cnt    <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
                end
                S_CHECK: begin
                    r_d <= w_d;
                    if (r_full) r_err <= (w_d != '0);
                    else        r_err <= w_d_big;
                end
                S_LOCATE: begin
                    // Scan every p so the phase length is always N cycles.
                    if (!r_found && w_match) begin
                        r_found <= 1'b1;
                        r_pos   <= r_cnt;
                        r_ins   <= (c_cw'(r_d) > c_cw'(r_weight));
                    end
                    r_ones <= r_ones + c_wt_w'(w_bit);
                    r_cnt  <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
                end
                S_EXTRACT: begin
                    data_out  <= w_data;
                    corrected <= r_found;
                    err       <= r_err | (!r_full && !r_found);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vt_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vt_decode                                               |
// | Description : Self-checking bench for vt_decode (K=5, N=10, a=0).        |
// |               Directed vectors, random full words, random single         |
// |               deletions of VT codewords, random short words, output      |
// |               back-pressure and asynchronous reset mid-decode.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vt_decode;

    localparam int N = 10;
    localparam int K = 5;
    localparam int M = 2 * N + 1;
    // out_valid is raised by edge T+N+2 (T = acceptance edge) so the sink
    // first samples it at edge T+N+3; a short word adds N locate cycles.
    localparam int LAT_FULL  = N + 2;
    localparam int LAT_SHORT = 2 * N + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_word;
    logic         in_full;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] data_out;
    logic         corrected;
    logic         err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [N-1:0] code_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vt_decode #(.K(K), .N(N), .SYNDROME_VAL(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_full   (in_full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .corrected (corrected),
        .err       (err)
    );

    // ---------------- reference model ----------------
    function automatic int vt_sum(input logic [N-1:0] w);
        int s = 0;
        for (int i = 0; i < N; i++) if (w[i]) s += i + 1;
        return s;
    endfunction

    // Data bits live at codeword indices 2,4,5,6,8.
    function automatic logic [K-1:0] get_data(input logic [N-1:0] w);
        return {w[8], w[6], w[5], w[4], w[2]};
    endfunction

    task automatic model_dec(input logic [N-1:0] w, input logic full,
                             output logic [K-1:0] d, output logic c, output logic e);
        logic [N-1:0] y;
        logic [N-1:0] r;
        int s, wt, dd, p, cnt;
        logic v, found;
        d = '0; c = 1'b0; e = 1'b0;
        if (full) begin
            dd = (M - vt_sum(w) % M) % M;
            e  = (dd != 0);
            d  = get_data(w);
        end else begin
            y  = {1'b0, w[N-2:0]};
            s  = vt_sum(y);
            wt = $countones(y);
            dd = (M - s % M) % M;
            if (dd > N) begin
                e = 1'b1;
            end else begin
                found = 1'b0; p = 0; v = 1'b0;
                for (int q = 0; q < N && !found; q++) begin
                    cnt = 0;
                    if (dd <= wt) begin
                        for (int t = q; t <= N - 2; t++) cnt += int'(y[t]);
                        if (cnt == dd) begin found = 1'b1; p = q; v = 1'b0; end
                    end else begin
                        for (int t = 0; t < q; t++) cnt += int'(!y[t]);
                        if (cnt == dd - wt - 1) begin found = 1'b1; p = q; v = 1'b1; end
                    end
                end
                for (int j = 0; j < N; j++) begin
                    if (j < p)       r[j] = y[j];
                    else if (j == p) r[j] = v;
                    else             r[j] = y[j-1];
                end
                d = get_data(r);
                c = found;
                e = !found;
            end
        end
    endtask

    // ---------------- transaction driver (called at a negedge) ----------------
    task automatic xfer(input logic [N-1:0] w, input logic f,
                        output logic [K-1:0] d, output logic c, output logic e,
                        output int lat);
        int t_acc;
        for (int i = 0; i < 64 && !in_ready; i++) @(negedge clk);
        in_valid = 1'b1; in_word = w; in_full = f;
        t_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            if (out_valid) begin lat = cyc - t_acc; break; end
            @(negedge clk);
        end
        d = data_out; c = corrected; e = err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_full = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== '0 ||
            corrected !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%b corr=%b err=%b required 1 0 00000 0 0",
                     in_ready, out_valid, data_out, corrected, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] vw [5] = '{10'h131, 10'h291, 10'h099, 10'h331, 10'h001};
        logic         vf [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [K-1:0] vd [5] = '{5'b10110, 5'b10110, 5'b10110, 5'b00000, 5'b00000};
        logic         vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic         ve [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int           vl [5] = '{LAT_FULL, LAT_SHORT, LAT_SHORT, LAT_FULL, LAT_FULL};
        logic [K-1:0] d; logic c, e; int lat;
        for (int i = 0; i < 5; i++) begin
            xfer(vw[i], vf[i], d, c, e, lat);
            checks++;
            if (lat !== vl[i]) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, vl[i]);
            end
            checks++;
            if (c !== vc[i] || e !== ve[i]) begin
                errors++;
                $display("FAIL dir%0d_flags: corr=%b err=%b required %b %b", i, c, e, vc[i], ve[i]);
            end
            if (!ve[i]) begin
                checks++;
                if (d !== vd[i]) begin
                    errors++;
                    $display("FAIL dir%0d_data: got %b required %b", i, d, vd[i]);
                end
            end
        end
    endtask

    task automatic test_random_full();
        logic [N-1:0] w; logic [K-1:0] d, md; logic c, e, mc, me; int lat;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) w = code_q[$urandom_range(0, code_q.size() - 1)];
            else            w = N'($urandom);
            model_dec(w, 1'b1, md, mc, me);
            xfer(w, 1'b1, d, c, e, lat);
            checks++;
            if (c !== mc || e !== me || lat !== LAT_FULL || (!me && d !== md)) begin
                errors++;
                $display("FAIL rand_full w=%h: data=%b corr=%b err=%b lat=%0d required %b %b %b %0d",
                         w, d, c, e, lat, md, mc, me, LAT_FULL);
            end
        end
    endtask

    task automatic test_random_deletion();
        logic [N-1:0] cw, y; logic [K-1:0] d; logic c, e; int del, lat;
        for (int i = 0; i < 16; i++) begin
            cw  = code_q[$urandom_range(0, code_q.size() - 1)];
            del = $urandom_range(0, N - 1);
            for (int j = 0; j < N - 1; j++) y[j] = (j < del) ? cw[j] : cw[j+1];
            y[N-1] = 1'($urandom);
            xfer(y, 1'b0, d, c, e, lat);
            checks++;
            if (d !== get_data(cw) || c !== 1'b1 || e !== 1'b0 || lat !== LAT_SHORT) begin
                errors++;
                $display("FAIL rand_del cw=%h del=%0d: data=%b corr=%b err=%b lat=%0d required %b 1 0 %0d",
                         cw, del, d, c, e, lat, get_data(cw), LAT_SHORT);
            end
        end
    endtask

    task automatic test_random_short();
        logic [N-1:0] w; logic [K-1:0] d, md; logic c, e, mc, me; int lat, ml;
        for (int i = 0; i < 12; i++) begin
            w = N'($urandom);
            model_dec(w, 1'b0, md, mc, me);
            ml = me ? LAT_FULL : LAT_SHORT;
            xfer(w, 1'b0, d, c, e, lat);
            checks++;
            if (c !== mc || e !== me || lat !== ml || (!me && d !== md)) begin
                errors++;
                $display("FAIL rand_short w=%h: data=%b corr=%b err=%b lat=%0d required %b %b %b %0d",
                         w, d, c, e, lat, md, mc, me, ml);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [K-1:0] d0; logic c0, e0; int t_acc, lat;
        in_valid = 1'b1; in_word = 10'h131; in_full = 1'b1;
        t_acc = cyc + 1;
        @(negedge clk);
        // A second request stays pending while the first is in flight.
        in_word = 10'h099; in_full = 1'b0;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            if (out_valid) begin lat = cyc - t_acc; break; end
            @(negedge clk);
        end
        checks++;
        if (lat !== LAT_FULL) begin
            errors++;
            $display("FAIL bp_first_latency: got %0d required %0d", lat, LAT_FULL);
        end
        d0 = data_out; c0 = corrected; e0 = err;
        checks++;
        if (d0 !== 5'b10110 || c0 !== 1'b0 || e0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_result: data=%b corr=%b err=%b required 10110 0 0", d0, c0, e0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== d0 ||
                corrected !== c0 || err !== e0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b data=%b corr=%b err=%b required 1 0 %b %b %b",
                         i, out_valid, in_ready, data_out, corrected, err, d0, c0, e0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        t_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: rdy=%b required 0", in_ready);
        end
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            if (out_valid) begin lat = cyc - t_acc; break; end
            @(negedge clk);
        end
        checks++;
        if (lat !== LAT_SHORT || data_out !== 5'b10110 || corrected !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_result: lat=%0d data=%b corr=%b err=%b required %0d 10110 1 0",
                     lat, data_out, corrected, err, LAT_SHORT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [K-1:0] d; logic c, e; int lat;
        in_valid = 1'b1; in_word = 10'h091; in_full = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (N + 4) @(negedge clk);   // now inside the locate phase
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_busy: rdy=%b vld=%b required 0 0", in_ready, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== '0 ||
            corrected !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate: rdy=%b vld=%b data=%b corr=%b err=%b required 1 0 00000 0 0",
                     in_ready, out_valid, data_out, corrected, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_abandon: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        xfer(10'h131, 1'b1, d, c, e, lat);
        checks++;
        if (d !== 5'b10110 || c !== 1'b0 || e !== 1'b0 || lat !== LAT_FULL) begin
            errors++;
            $display("FAIL ar_after: data=%b corr=%b err=%b lat=%0d required 10110 0 0 %0d",
                     d, c, e, lat, LAT_FULL);
        end
    endtask

    initial begin
        for (int w = 0; w < (1 << N); w++) begin
            if (vt_sum(N'(w)) % M == 0) code_q.push_back(N'(w));
        end
        test_reset();
        test_directed();
        test_random_full();
        test_random_deletion();
        test_random_short();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vt_decode.md
Name: vt_decode

Overview:
- Sequential single-deletion-correcting Varshamov-Tenengolts decoder.
- Receive-side counterpart of the team's VT encoder.
- Accepts either a full n-bit word or an (n-1)-bit word with one deletion. Computes the VT checksum serially, restores a deleted bit if needed, and extracts the k information bits.
- Sits between the channel deframer and the data sink, with valid/ready handshakes on both sides.

Parameters:
- k, 5: number of information bits.
- n, 10: codeword length. Must equal the smallest n with n - clog2(n) - 1 >= k, the same rule the encoder uses.
- SYNDROME_VAL, 0: VT residue a. Modulus m = 2n+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word.
- in_word  in  n  received word, bit i = position i+1. For a short word, only bits [n-2:0] are meaningful; bit n-1 is ignored.
- in_full  in  1  1 = n-bit word; 0 = (n-1)-bit word (one deletion).
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- data_out  out  k  decoded information bits.
- corrected  out  1  a deleted bit was reinserted.
- err  out  1  word not decodable; data_out is don't-care.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - in_ready=1; out_valid=0; data_out=0; corrected=0; err=0.
  - Internal sum, weight and counters are cleared.
  - Reset mid-operation abandons the word; no output is produced.
- Data/parity map, identical to the encoder:
  - Parity at 0-based indices i where (i+1)&i==0.
  - Parity also at index n-1 if k + clog2(last_pow2_index+1) + 1 < n.
  - Remaining indices carry data_in[0..k-1] in ascending order.
  - For k=5, n=10: parity at 0,1,3,7,9; data at 2,4,5,6,8.
- FSM:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_word and in_full, then go to SUM.
  - SUM, n cycles, one bit per cycle:
    - sum += (i+1)*bit; weight += bit.
    - For a short word, bit n-1 is forced to 0.
    - sum width is clog2(n(n+1)/2+1); weight width is clog2(n+1).
  - CHECK, 1 cycle: D = (SYNDROME_VAL - sum) mod m, in range 0..m-1.
    - Full word: D==0 → EXTRACT with err=0. D!=0 → EXTRACT with err=1.
    - Short word: D>n → err=1, go to EXTRACT. Otherwise go to LOCATE.
  - LOCATE, exactly n cycles, fixed for verification. Let y be the short word, p the insertion index 0..n-1.
    - If D<=weight: insert 0 at the smallest p such that the number of ones in y[p..n-2] equals D.
    - Else: insert 1 at the smallest p such that the number of zeros in y[0..p-1] equals D-weight-1.
    - Rebuilt word: bits below p unchanged, bit p = inserted value, bits above p shifted up by one.
    - corrected=1.
  - EXTRACT, 1 cycle: gather data bits from the (rebuilt) word into data_out. Go to OUT.
  - OUT: out_valid=1; outputs held stable.
    - On out_ready, return to IDLE. out_valid drops in the next cycle.
    - in_ready goes high in that same cycle.
- in_ready is 0 in every state except IDLE. There is no pipelining: one word in flight.
- Latency, with acceptance at edge T:
  - Full word: out_valid first high at T+n+3.
  - Short word: T+2n+3. An err from CHECK on a short word follows the full-word timing.
- corrected and err are never both 1.
- out_valid is asserted even when err=1.

Test Plan:
- Full word, k=5, n=10, a=0: in_word=10'h131, in_full=1 → data_out=5'b10110, corrected=0, err=0, out_valid at T+13.
- Deleted 1 at index 4: in_word=9'h091, in_full=0.
  - Expected internals: sum=14, weight=3, D=7, insert 1 at p=4.
  - Expected outputs: data_out=5'b10110, corrected=1, err=0, out_valid at T+23.
- Deleted 0 at index 2: in_word=9'h099, in_full=0.
  - Expected internals: sum=18, weight=4, D=3, insert 0 at p=1.
  - Expected outputs: data_out=5'b10110, corrected=1.
- Undecodable cases:
  - in_word=10'h331, in_full=1 → D=11, err=1.
  - in_word=9'h001, in_full=0 → D=20>n, err=1, corrected=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 → next word is accepted the cycle after.
- Async reset: drop rst_n during LOCATE → all outputs go to reset values immediately. After release, word 10'h131 decodes correctly.
